// File: rtl/div_16x8_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_16x8_seq
// Description : Sequential restoring divider that recovers the 8-bit operand
//               A = R / B and remainder REM = R mod B from a 16-bit product R
//               and an 8-bit operand B. Resolves one quotient bit per clock
//               and uses a single-issue start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module div_16x8_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] R,
    input  logic [7:0]  B,
    output logic [7:0]  A,
    output logic [7:0]  REM,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic        ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] c_LAST_ITER = 3'd7;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [7:0] r_p;      // partial remainder; always < divisor between iterations
    logic [7:0] r_d;      // remaining dividend bits, consumed MSB-first
    logic [7:0] r_b;      // divisor captured at accept
    logic [2:0] r_cnt;    // iteration index 0..7

    logic       w_accept;
    logic       w_is_div0;
    logic       w_is_ovf;
    logic [8:0] w_t;
    logic       w_qbit;
    logic [7:0] w_diff;
    logic [7:0] w_p_next;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_is_div0 = (B == 8'd0);
    // A high byte >= B means the quotient cannot fit in 8 bits.
    assign w_is_ovf  = !w_is_div0 && (R[15:8] >= B);

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // The difference is taken modulo 256 because the true result is < B.
    assign w_t      = {r_p, r_d[7]};
    assign w_qbit   = (w_t >= {1'b0, r_b});
    assign w_diff   = w_t[7:0] - r_b;
    assign w_p_next = w_qbit ? w_diff : w_t[7:0];

    // Status outputs are pure decodes of the state register.
    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; special cases bypass CALC and finish immediately.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_is_div0 || w_is_ovf) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (r_cnt == c_LAST_ITER) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one quotient bit per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A     <= 8'd0;
            REM   <= 8'd0;
            div0  <= 1'b0;
            ovf   <= 1'b0;
            r_p   <= 8'd0;
            r_d   <= 8'd0;
            r_b   <= 8'd0;
            r_cnt <= 3'd0;
        end else if (w_accept) begin
            div0  <= 1'b0;
            ovf   <= 1'b0;
            r_b   <= B;
            r_cnt <= 3'd0;
            if (w_is_div0) begin
                div0 <= 1'b1;
                A    <= 8'hFF;
                REM  <= 8'h00;
            end else if (w_is_ovf) begin
                ovf  <= 1'b1;
                A    <= 8'hFF;
                REM  <= 8'h00;
            end else begin
                r_p <= R[15:8];
                r_d <= R[7:0];
            end
        end else if (r_state == S_CALC) begin
            r_p   <= w_p_next;
            r_d   <= {r_d[6:0], 1'b0};
            A     <= {A[6:0], w_qbit};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == c_LAST_ITER) begin
                REM <= w_p_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_16x8_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_div_16x8_seq
// Description : Self-checking bench for div_16x8_seq. Expected results are
//               pushed to a scoreboard queue at start and popped when done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_16x8_seq;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] rem;
        logic       div0;
        logic       ovf;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] R;
    logic [7:0]  B;
    logic [7:0]  A;
    logic [7:0]  REM;
    logic        busy;
    logic        done;
    logic        div0;
    logic        ovf;

    int   checks;
    int   errors;
    res_t sb[$];

    div_16x8_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .R     (R),
        .B     (B),
        .A     (A),
        .REM   (REM),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the divider result.
    function automatic res_t model(input logic [15:0] r, input logic [7:0] b);
        res_t e;
        e = '0;
        if (b == 8'd0) begin
            e.a = 8'hFF; e.div0 = 1'b1;
        end else if (r[15:8] >= b) begin
            e.a = 8'hFF; e.ovf = 1'b1;
        end else begin
            e.a   = 8'(r / {8'd0, b});
            e.rem = 8'(r % {8'd0, b});
        end
        return e;
    endfunction

    function automatic int model_lat(input logic [15:0] r, input logic [7:0] b);
        return ((b == 8'd0) || (r[15:8] >= b)) ? 0 : 8;
    endfunction

    // Pops the oldest expected result; an empty queue yields X so the compare fails.
    function automatic res_t next_exp();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    // Drives one start pulse from a falling edge; returns on the falling edge after accept.
    task automatic start_op(input logic [15:0] r, input logic [7:0] b);
        R = r; B = b; start = 1'b1;
        sb.push_back(model(r, b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until done is seen, bounded to 20.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; R = '0; B = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({A, REM, busy, done, div0, ovf} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {A, REM, busy, done, div0, ovf});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle busy/done got %b required 00", {busy, done});
        end
    endtask

    task automatic test_basic();
        int busy_cnt, done_cnt, done_k;
        res_t got, exp;
        busy_cnt = 0; done_cnt = 0; done_k = -1;
        exp = '0;
        start_op(16'd1000, 8'd7);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    got = {A, REM, div0, ovf};
                    exp = next_exp();
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL basic_result got %h required %h", got, exp);
                    end
                end
            end
        end
        checks++;
        if (done_k != 8) begin errors++; $display("FAIL basic_latency got %0d required 8", done_k); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL basic_done_width got %0d required 1", done_cnt); end
        checks++;
        if (busy_cnt != 9) begin errors++; $display("FAIL basic_busy_cycles got %0d required 9", busy_cnt); end
    endtask

    task automatic test_boundary();
        logic [15:0] rs [2];
        logic [7:0]  bs [2];
        res_t        want [2];
        int          lat;
        res_t        got, exp;
        rs[0] = 16'hFE02; bs[0] = 8'd255; want[0] = {8'd255, 8'd1, 1'b0, 1'b0};
        rs[1] = 16'hFE00; bs[1] = 8'd255; want[1] = {8'd254, 8'd254, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            start_op(rs[i], bs[i]);
            wait_done(lat);
            got = {A, REM, div0, ovf};
            exp = next_exp();
            checks++;
            if (got !== want[i] || exp !== want[i] || lat != 8) begin
                errors++;
                $display("FAIL boundary_%0d got %h lat %0d required %h lat 8", i, got, lat, want[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_special();
        logic [15:0] rs [3];
        logic [7:0]  bs [3];
        res_t        want [3];
        int          lat;
        res_t        got, exp;
        rs[0] = 16'h0800; bs[0] = 8'd8;   want[0] = {8'hFF, 8'h00, 1'b0, 1'b1};
        rs[1] = 16'd500;  bs[1] = 8'd0;   want[1] = {8'hFF, 8'h00, 1'b1, 1'b0};
        rs[2] = 16'h07FF; bs[2] = 8'd8;   want[2] = {8'd255, 8'd7, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            start_op(rs[i], bs[i]);
            wait_done(lat);
            got = {A, REM, div0, ovf};
            exp = next_exp();
            checks++;
            if (got !== want[i] || exp !== want[i] || lat != ((i == 2) ? 8 : 0)) begin
                errors++;
                $display("FAIL special_%0d got %h lat %0d required %h", i, got, lat, want[i]);
            end
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b00 || {A, REM, div0, ovf} !== want[i]) begin
                errors++;
                $display("FAIL special_hold_%0d got busy/done %b res %h required 00 %h",
                         i, {busy, done}, {A, REM, div0, ovf}, want[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int   lat, extra_done;
        res_t got, exp;
        extra_done = 0;
        start_op(16'd1000, 8'd7);
        repeat (3) @(negedge clk);
        R = 16'd9; B = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; R = '0; B = '0;
        wait_done(lat);
        got = {A, REM, div0, ovf};
        exp = next_exp();
        checks++;
        if (got !== exp || lat != 4) begin
            errors++;
            $display("FAIL ignore_result got %h lat %0d required %h lat 4", got, lat, exp);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        checks++;
        if (extra_done != 0 || A !== 8'd142 || REM !== 8'd6) begin
            errors++;
            $display("FAIL ignore_no_second got extra %0d A %0d REM %0d required 0 142 6",
                     extra_done, A, REM);
        end
    endtask

    task automatic test_midreset();
        int   lat;
        res_t got, exp;
        start_op(16'd1000, 8'd7);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({A, REM, busy, done, div0, ovf} !== 20'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %h required 0", {A, REM, busy, done, div0, ovf});
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(16'd255, 8'd1);
        wait_done(lat);
        got = {A, REM, div0, ovf};
        exp = next_exp();
        checks++;
        if (got !== exp || got !== {8'd255, 8'd0, 1'b0, 1'b0} || lat != 8) begin
            errors++;
            $display("FAIL midreset_recover got %h lat %0d required %h lat 8", got, lat, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] r;
        logic [7:0]  a, b;
        int          mode, err, lat, want_lat;
        res_t        got, exp;
        for (int i = 0; i < 3000; i++) begin
            mode = int'($urandom_range(0, 3));
            a = 8'($urandom);
            b = 8'($urandom);
            if (mode <= 1) begin
                r = 16'(a) * 16'(b);
            end else if (mode == 2) begin
                err = int'($urandom_range(0, 16)) - 8;
                r = 16'(int'(16'(a) * 16'(b)) + err);
            end else begin
                r = 16'($urandom);
            end
            want_lat = model_lat(r, b);
            start_op(r, b);
            wait_done(lat);
            got = {A, REM, div0, ovf};
            exp = next_exp();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_result R %h B %h got %h required %h", r, b, got, exp);
            end
            checks++;
            if (lat != want_lat) begin
                errors++;
                $display("FAIL random_latency R %h B %h got %0d required %0d", r, b, lat, want_lat);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        R      = '0;
        B      = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_boundary();
        test_special();
        test_ignore_start();
        test_midreset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
